// File: rtl/debug_disp_pkg.sv
// Shared constants for the debug display: blank pattern and the
// active-low hex glyph table, ordered {g,f,e,d,c,b,a}.
package debug_disp_pkg;

    typedef logic [6:0] seg_t;

    // All segments off (active-low).
    localparam seg_t SEG_BLANK = 7'h7F;

    // Glyphs for 0..F; index 15 is the leftmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import debug_disp_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_n
);

    // Straight table lookup; all 16 codes are defined.
    always_comb begin
        o_seg_n = SEG_TABLE[i_hex];
    end

endmodule

// File: rtl/debug_display_mux.sv
// Multiplexed hex display of one of NUM_CH debug channels.
// A prescaler steps a digit index; each completed scan (frame) reloads a
// snapshot of the selected channel unless freeze is high. A synchronised
// pushbutton (step) selects the next channel; the decimal point marks the
// digit whose position equals the selected channel.
// Optional feature: define DEBUG_DISP_AUTOCYCLE_EN to also advance the
// channel automatically every AUTO_FRAMES frames.
module debug_display_mux
    import debug_disp_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 32,
    parameter int DIGITS      = DATA_W / 4,
    parameter int PRESCALE    = 50000,
    parameter int AUTO_FRAMES = 2000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     step,
    input  logic                     freeze,
    output logic [6:0]               seg_n,
    output logic                     dp_n,
    output logic [DIGITS-1:0]        an_n,
    output logic [CH_W-1:0]          ch_idx
);

    localparam int PS_W  = $clog2(PRESCALE);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    // Scan state
    logic [PS_W-1:0]   r_presc;
    logic [DIG_W-1:0]  r_digit;
    logic              r_active;
    logic [DATA_W-1:0] r_snap;
    logic              r_reload_pend;

    // Pushbutton synchroniser and edge register
    logic              r_step_s1;
    logic              r_step_s2;
    logic              r_step_s3;
    logic              r_step_edge;

    logic [CH_W-1:0]   r_ch_idx;

    // Registered outputs
    seg_t              r_seg_n;
    logic              r_dp_n;
    logic [DIGITS-1:0] r_an_n;

    logic              w_slot_tick;
    logic              w_frame_tick;
    logic              w_auto;
    logic              w_advance;
    logic [CH_W-1:0]   w_ch_next;
    logic              w_ch_change;
    logic [DATA_W-1:0] w_chan [NUM_CH];
    logic [DATA_W-1:0] w_sel_data;
    logic [3:0]        w_nibble;
    logic [6:0]        w_glyph;
    logic [DIGITS-1:0] w_an_n;
    logic              w_dp_hit;

    assign w_slot_tick  = (r_presc == PS_LAST);
    // The first slot tick only arms the scan; frames are counted afterwards.
    assign w_frame_tick = w_slot_tick && r_active && (r_digit == DIG_LAST);

    assign w_advance   = r_step_edge | w_auto;
    assign w_ch_next   = (r_ch_idx == CH_LAST) ? '0 : r_ch_idx + 1'b1;
    // With a single channel the next index equals the current one.
    assign w_ch_change = w_advance && (w_ch_next != r_ch_idx);

    // Split the packed channel bus into one word per channel.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_chan[gi] = ch_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Select the currently displayed channel word.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_idx == CH_W'(i)) begin
                w_sel_data = w_chan[i];
            end
        end
    end

    // Nibble for the active digit; digits past the data width show zero.
    assign w_nibble = 4'(r_snap >> {r_digit, 2'b00});

    hex_to_seg7 u_glyph (
        .i_hex   (w_nibble),
        .o_seg_n (w_glyph)
    );

    // One-hot active-low anode pattern for the current digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
            assign w_an_n[gi] = (r_digit != DIG_W'(gi));
        end
    endgenerate

    assign w_dp_hit = (int'(r_digit) == int'(r_ch_idx));

`ifdef DEBUG_DISP_AUTOCYCLE_EN
    localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

    logic [FC_W-1:0] r_frame_cnt;

    assign w_auto = w_frame_tick && (r_frame_cnt == FC_LAST);

    // Count frames toward the next automatic advance; a step restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (r_step_edge || w_auto) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end
`else
    // Auto-advance compiled out: this comparison is always false.
    assign w_auto = (AUTO_FRAMES < 0);
`endif

    // Prescaler and digit index; the first slot tick after reset starts at digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            r_digit  <= '0;
            r_active <= 1'b0;
        end else begin
            r_presc <= w_slot_tick ? '0 : r_presc + 1'b1;
            if (w_slot_tick) begin
                if (!r_active) begin
                    r_active <= 1'b1;
                end else begin
                    r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
                end
            end
        end
    end

    // Two-flop synchroniser, delay flop and registered rising-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_s1   <= 1'b0;
            r_step_s2   <= 1'b0;
            r_step_s3   <= 1'b0;
            r_step_edge <= 1'b0;
        end else begin
            r_step_s1   <= step;
            r_step_s2   <= r_step_s1;
            r_step_s3   <= r_step_s2;
            r_step_edge <= r_step_s2 & ~r_step_s3;
        end
    end

    // Channel select: a coincident step and auto tick advance only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_idx <= '0;
        end else if (w_advance) begin
            r_ch_idx <= w_ch_next;
        end
    end

    // Snapshot reload on frame ticks; a channel change overrides freeze once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap        <= '0;
            r_reload_pend <= 1'b0;
        end else begin
            if (w_frame_tick && (!freeze || r_reload_pend)) begin
                r_snap <= w_sel_data;
            end
            if (w_ch_change) begin
                r_reload_pend <= 1'b1;
            end else if (w_frame_tick) begin
                r_reload_pend <= 1'b0;
            end
        end
    end

    // Output registers: blank until scanning starts, then follow the digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
        end else if (!r_active) begin
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
        end else begin
            r_seg_n <= w_glyph;
            r_dp_n  <= ~w_dp_hit;
            r_an_n  <= w_an_n;
        end
    end

    assign seg_n  = r_seg_n;
    assign dp_n   = r_dp_n;
    assign an_n   = r_an_n;
    assign ch_idx = r_ch_idx;

endmodule

// File: doc/debug_display_mux.md
DEBUG_DISPLAY_MUX -- requirements
Module: debug_display_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of debug channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, bits per channel (multiple of 4).
REQ-003 SHALL have parameter DIGITS, default DATA_W/4, number of multiplexed hex digits.
REQ-004 SHALL have parameter PRESCALE, default 50000, clk cycles per digit slot (>=2).
REQ-005 SHALL have parameter AUTO_FRAMES, default 2000, scan frames per automatic channel advance.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port ch_data, input, NUM_CH*DATA_W, packed channels, channel 0 in LSBs.
REQ-009 SHALL have port step, input, 1, asynchronous pushbutton that advances the channel.
REQ-010 SHALL have port freeze, input, 1, holds the current snapshot while high.
REQ-011 SHALL have port seg_n, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp_n, output, 1, active-low decimal point.
REQ-013 SHALL have port an_n, output, DIGITS, active-low one-hot digit enable.
REQ-014 SHALL have port ch_idx, output, $clog2(NUM_CH) (min 1), currently selected channel.

Function
REQ-015 SHALL count prescale 0..PRESCALE-1 and wrap; a slot tick occurs when count is PRESCALE-1.
REQ-016 SHALL advance the digit index 0..DIGITS-1 on each slot tick and wrap DIGITS-1 -> 0; the wrap is a frame tick.
REQ-017 SHALL drive an_n low only at bit digit index; all other bits high.
REQ-018 SHALL drive seg_n with the hex glyph of snapshot nibble [4*d+3:4*d] for digit index d.
REQ-019 SHALL load the snapshot from the selected channel on every frame tick, unless freeze is high.
REQ-020 SHALL assert dp_n low only when digit index equals ch_idx, marking the channel.
REQ-021 SHALL synchronise step through two flops and rising-edge detect it with a third flop.
REQ-022 SHALL increment ch_idx exactly 3 clk cycles after step is first sampled high, once per press.
REQ-023 SHALL wrap ch_idx from NUM_CH-1 to 0; if NUM_CH=1, ch_idx stays 0.
REQ-024 SHALL advance ch_idx by exactly one when a step edge and an auto advance occur in the same cycle.
REQ-025 SHALL force a snapshot reload on the frame tick after a channel change, even if freeze is high.
REQ-026 SHALL keep seg_n, dp_n and an_n registered, glitch-free, one cycle after the digit index changes.

Reset
REQ-027 SHALL, while rst is high, set seg_n=7'h7F, dp_n=1, an_n all ones, ch_idx=0, counters=0, snapshot=0, sync flops=0.
REQ-028 SHALL leave all outputs blank after rst is released until the first slot tick, then start scanning at digit 0.
REQ-029 SHALL abort any pending step edge or auto advance on rst assertion mid-operation, with no advance on release.

Configuration
REQ-030 SHALL, with DEBUG_DISP_AUTOCYCLE_EN defined, count frame ticks and advance ch_idx every AUTO_FRAMES frames; a step edge restarts that count.
REQ-031 SHALL, without DEBUG_DISP_AUTOCYCLE_EN, omit the frame counter and change ch_idx only on step.

Structure
REQ-032 SHALL place the 16-entry hex-to-segment constant table and SEG_BLANK (7'h7F) in shared package debug_disp_pkg.
REQ-033 SHALL implement the glyph lookup as one combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out).

Verification
REQ-034 SHALL verify: PRESCALE=4, DIGITS=8, ch_data ch0=32'h1234ABCD -> an_n scans FE,FD,...,7F, 4 cycles each; seg_n glyphs D,C,B,A,4,3,2,1.
REQ-035 SHALL verify: step pulse 1 cycle wide, NUM_CH=3, ch_idx=2 -> ch_idx=0 exactly 3 cycles later; a 20-cycle press advances only once.
REQ-036 SHALL verify: freeze=1 and ch0 changes to 32'hFFFFFFFF -> display keeps 1234ABCD; after step, the next frame shows ch1.
REQ-037 SHALL verify: rst asserted mid-scan at digit 5 -> same-cycle async clear to seg_n=7F, an_n=FF, ch_idx=0.
REQ-038 SHALL verify: with DEBUG_DISP_AUTOCYCLE_EN and AUTO_FRAMES=2, a step edge coinciding with the auto tick -> ch_idx increments by exactly 1.
REQ-039 SHALL verify: dp_n is low only while an_n bit ch_idx is low, for ch_idx 0, 1 and 2.
